// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path.
//   rx_state_e    - receiver FSM states (IDLE=0 .. STOP=4)
//   PAR_EVEN/ODD  - encodings of the PAR_TYP input
//   MIN/MAX_PRESCALE - legal range of oversampling clocks per bit
//   norm_prescale - maps a raw PRESCALE value onto the even, legal value used
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [5:0] MIN_PRESCALE = 6'd4;
  localparam logic [5:0] MAX_PRESCALE = 6'd32;

  // Odd values round down so that the mid-bit point P/2 is an integer;
  // anything outside the legal range is pinned to the nearest limit.
  function automatic logic [5:0] norm_prescale(input logic [5:0] raw);
    logic [5:0] even;
    logic [5:0] res;
    even = {raw[5:1], 1'b0};
    res  = even;
    if (even < MIN_PRESCALE) res = MIN_PRESCALE;
    if (even > MAX_PRESCALE) res = MAX_PRESCALE;
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side inputs, frame configuration and byte-side results
// of the UART receiver.
//   RX_IN      - serial line, idles high
//   PAR_EN     - frame carries a parity bit
//   PAR_TYP    - 0 even, 1 odd parity
//   PRESCALE   - clock cycles per bit
//   P_DATA     - last error-free byte received
//   DATA_VALID - one-cycle pulse, P_DATA just updated
//   PAR_ERR    - one-cycle pulse, parity mismatch
//   STP_ERR    - one-cycle pulse, stop bit sampled low
//   BUSY       - receiver is inside a frame
// master: the side that drives the line and configuration (and consumes bytes).
// slave:  the receiver itself.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            PRESCALE;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_ERR;
  logic                  STP_ERR;
  logic                  BUSY;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, PRESCALE,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, PRESCALE,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit oversampling counter and 2-of-3 majority vote.
//   CLK, RST     - oversampling clock, async active-low reset
//   clr          - hold edge_cnt at 0 (receiver idle next cycle)
//   prescale     - latched, even clock count per bit (>= 4)
//   rx_s         - synchronized serial line
//   sampled_bit  - majority of the samples at edge_cnt P/2-1, P/2, P/2+1
//   sample_valid - sampled_bit is meaningful this cycle (edge_cnt = P/2+1)
//   bit_end      - last cycle of the current bit (edge_cnt = P-1)
module uart_rx_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr,
  input  logic [5:0] prescale,
  input  logic       rx_s,
  output logic       sampled_bit,
  output logic       sample_valid,
  output logic       bit_end
);

  logic [5:0] edge_cnt;
  logic [5:0] half;
  logic       smp0_q;
  logic       smp1_q;

  assign half = {1'b0, prescale[5:1]};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      smp0_q   <= 1'b0;
      smp1_q   <= 1'b0;
    end else begin
      if (clr || bit_end) edge_cnt <= '0;
      else                edge_cnt <= edge_cnt + 6'd1;
      if (edge_cnt == half - 6'd1) smp0_q <= rx_s;
      if (edge_cnt == half)        smp1_q <= rx_s;
    end
  end

  // The third sample is taken live, so the vote is ready in the same cycle
  // as the last sample; the consumer registers it. This keeps the vote
  // inside the bit even at the minimum prescale of 4.
  assign sampled_bit  = (smp0_q & smp1_q) | (smp0_q & rx_s) | (smp1_q & rx_s);
  assign sample_valid = (edge_cnt == half + 6'd1);
  assign bit_end      = (edge_cnt == prescale - 6'd1);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver (start bit, DATA_WIDTH data bits LSB first,
// optional parity, one stop bit), oversampled by a runtime prescale.
//   CLK - oversampling clock (PRESCALE x baud)
//   RST - asynchronous active-low reset
//   bus - uart_rx_if slave: RX_IN/config in, P_DATA/pulses/BUSY out
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic    CLK,
  input  logic    RST,
  uart_rx_if.slave bus
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  rx_state_e state_q, state_d;

  logic [5:0]            presc_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_flag_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;

  logic sampled_bit;
  logic sample_valid;
  logic bit_end;
  logic cnt_clr;
  logic start_det;
  logic last_bit;
  logic exp_par;

  // Input synchronizer; resets to the idle (high) line level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_rx_sampler u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .clr          (cnt_clr),
    .prescale     (presc_q),
    .rx_s         (rx_s),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .bit_end      (bit_end)
  );

  // The falling-edge detect cycle counts as edge 0 of the start bit, so the
  // counter is only held at zero while the receiver stays idle.
  assign cnt_clr   = (state_d == IDLE);
  assign start_det = (state_q == IDLE) && !rx_s;
  assign last_bit  = (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1));
  assign exp_par   = (^shift_q) ^ (par_typ_q == PAR_ODD);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rx_s) state_d = START;
      // A high majority at mid start bit is a glitch, not a frame.
      START:  if (sample_valid && sampled_bit) state_d = IDLE;
              else if (bit_end)                state_d = DATA;
      DATA:   if (bit_end && last_bit) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      // Leave as soon as the stop bit is voted so a following start edge,
      // possibly from a slightly fast transmitter, is not missed.
      STOP:   if (sample_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame configuration, bit counter, parity flag and result registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q      <= MIN_PRESCALE;
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      bit_cnt_q    <= '0;
      par_flag_q   <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;

      if (start_det) begin
        presc_q    <= norm_prescale(bus.PRESCALE);
        par_en_q   <= bus.PAR_EN;
        par_typ_q  <= bus.PAR_TYP;
        bit_cnt_q  <= '0;
        par_flag_q <= 1'b0;
      end

      if (state_q == DATA && bit_end)
        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + BIT_CNT_W'(1);

      if (state_q == PARITY && sample_valid)
        par_flag_q <= (sampled_bit != exp_par);

      if (state_q == STOP && sample_valid) begin
        par_err_q    <= par_flag_q;
        stp_err_q    <= !sampled_bit;
        data_valid_q <= !par_flag_q && sampled_bit;
        if (!par_flag_q && sampled_bit) p_data_q <= shift_q;
      end
    end
  end

  // Deserializer: LSB arrives first, so bits enter at the top and shift down.
  always_ff @(posedge CLK) begin
    if (state_q == DATA && sample_valid)
      shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.DATA_VALID = data_valid_q;
  assign bus.PAR_ERR    = par_err_q;
  assign bus.STP_ERR    = stp_err_q;
  assign bus.BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames for uart_rx, checked by a
// scoreboard fed from a frame-level reference model.
module tb_uart_rx;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_rx_if #(.DATA_WIDTH(W)) bus ();

  uart_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic         dv;
    logic         pe;
    logic         se;
    logic [W-1:0] data;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] last_good = '0;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding frame.
  always @(negedge CLK) begin
    if (RST && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {29'd0, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_flags", {29'd0, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR},
              {29'd0, mon_e.dv, mon_e.pe, mon_e.se});
        check("p_data", {24'd0, bus.P_DATA}, {24'd0, mon_e.data});
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, %0d outstanding frames", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic int period_of(input int raw);
    int e;
    e = raw - (raw % 2);
    if (e < 4)  e = 4;
    if (e > 32) e = 32;
    return e;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int p);
    bus.RX_IN = b;
    wait_cycles(p);
  endtask

  // Sends one frame and queues the result the receiver must report.
  task automatic send_frame(input logic [W-1:0] d, input int praw, input logic pen,
                            input logic ptyp, input logic par_flip, input logic stop_bit,
                            input int gap, input logic scramble);
    int   p;
    int   g;
    logic sent_par;
    exp_t e;
    p  = period_of(praw);
    g  = gap;
    if (!stop_bit && g < 2 * p) g = 2 * p;
    bus.PRESCALE = 6'(praw);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    // Parity bit that makes the total number of ones even (or odd), then
    // optionally corrupted.
    sent_par = logic'(($countones(d) % 2) == 1) ^ ptyp ^ par_flip;
    e.pe   = pen && ((($countones(d) + int'(sent_par)) % 2) != (ptyp ? 1 : 0));
    e.se   = !stop_bit;
    e.dv   = !e.pe && !e.se;
    e.data = e.dv ? d : last_good;
    if (e.dv) last_good = d;
    exp_q.push_back(e);

    drive_bit(1'b0, p);
    if (scramble) begin
      bus.PRESCALE = 6'($urandom);
      bus.PAR_EN   = 1'($urandom);
      bus.PAR_TYP  = 1'($urandom);
    end
    for (int i = 0; i < W; i++) drive_bit(d[i], p);
    bus.PRESCALE = 6'(praw);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    if (pen) drive_bit(sent_par, p);
    drive_bit(stop_bit, p);
    bus.RX_IN = 1'b1;
    if (g > 0) wait_cycles(g);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge CLK);
      n++;
    end
    wait_cycles(2);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] d;
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.PRESCALE = 6'd8;
    wait_cycles(3);
    RST = 1'b1;
    wait_cycles(2);

    check("reset_p_data",     {24'd0, bus.P_DATA}, 32'd0);
    check("reset_data_valid", {31'd0, bus.DATA_VALID}, 32'd0);
    check("reset_par_err",    {31'd0, bus.PAR_ERR}, 32'd0);
    check("reset_stp_err",    {31'd0, bus.STP_ERR}, 32'd0);
    check("reset_busy",       {31'd0, bus.BUSY}, 32'd0);

    // Good frame with even parity, then the same frame with a bad parity bit.
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b0);
    drain("drain_parity");

    // Stop bit low, receiver must recover and take the next frame.
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 32, 1'b0);
    check("busy_after_stop_err", {31'd0, bus.BUSY}, 32'd0);
    send_frame(8'h81, 16, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    drain("drain_stop_err");

    // Two-cycle glitch: the start is rejected without any result pulse.
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 2);
    check("glitch_busy_set", {31'd0, bus.BUSY}, 32'd1);
    wait_cycles(12);
    check("glitch_busy_clear", {31'd0, bus.BUSY}, 32'd0);

    // Back-to-back frames, odd parity, slowest rate.
    send_frame(8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1, 32, 1'b0);
    drain("drain_back_to_back");

    // Reset in the middle of data bit 4.
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    d = 8'hC3;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
    drive_bit(d[4], 4);
    check("busy_before_reset", {31'd0, bus.BUSY}, 32'd1);
    #2 RST = 1'b0;
    #1;
    check("midreset_p_data",     {24'd0, bus.P_DATA}, 32'd0);
    check("midreset_data_valid", {31'd0, bus.DATA_VALID}, 32'd0);
    check("midreset_par_err",    {31'd0, bus.PAR_ERR}, 32'd0);
    check("midreset_stp_err",    {31'd0, bus.STP_ERR}, 32'd0);
    check("midreset_busy",       {31'd0, bus.BUSY}, 32'd0);
    last_good = '0;
    wait_cycles(3);
    bus.RX_IN = 1'b1;
    wait_cycles(2);
    RST = 1'b1;
    wait_cycles(4);
    check("busy_after_reset", {31'd0, bus.BUSY}, 32'd0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b0);
    drain("drain_after_reset");

    // Random frames: raw prescale including odd and too-small values,
    // random parity/stop faults, gaps and mid-frame configuration noise.
    for (int n = 0; n < 40; n++) begin
      int praw;
      praw = int'($urandom_range(0, 33));
      send_frame(8'($urandom), praw, 1'($urandom), 1'($urandom),
                 logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 5) != 0),
                 int'($urandom_range(0, 2 * period_of(praw))), 1'b1);
    end
    drain("drain_random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
